// File: rtl/fp_vector_packer.sv
// Serial-to-parallel packer: gathers bfloat16 operands into an ITEMS-wide vector
// for fp_add_tree, padding lanes left unused by an early flush with +0.0.
module fp_vector_packer #(
   parameter int WIDTH = 16,
   parameter int ITEMS = 32,
   parameter int CW    = $clog2(ITEMS + 1)
) (
   input  logic                         clock,
   input  logic                         clock_sreset,
   input  logic                         in_valid,
   input  logic [WIDTH-1:0]             in_data,
   input  logic                         in_last,
   output logic                         in_ready,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [ITEMS-1:0][WIDTH-1:0]  out_data,
   output logic [CW-1:0]                out_count
);

   typedef enum logic {FILL, HOLD} state_t;

   state_t                      state_reg, state_next;
   logic [CW-1:0]               cnt_reg, cnt_next;
   logic [ITEMS-1:0][WIDTH-1:0] fill_reg, fill_next, fill_merged;
   logic [ITEMS-1:0][WIDTH-1:0] out_data_reg, out_data_next;
   logic [CW-1:0]               out_count_reg, out_count_next;
   logic                        out_valid_reg, out_valid_next;
   logic                        accept, complete, slot_free, load;

   assign in_ready  = (state_reg == FILL);
   assign accept    = in_valid & in_ready;
   assign complete  = accept & (in_last | (cnt_reg == CW'(ITEMS - 1)));
   assign slot_free = ~out_valid_reg | out_ready;

   // Lanes above cnt are already zero because the buffer is cleared on every
   // hand-off, so merging the incoming element yields the padded vector.
   generate
      for (genvar gi = 0; gi < ITEMS; gi++) begin : g_merge
         assign fill_merged[gi] = (accept && cnt_reg == CW'(gi)) ? in_data : fill_reg[gi];
      end
   endgenerate

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      fill_next      = fill_reg;
      out_data_next  = out_data_reg;
      out_count_next = out_count_reg;
      load           = 1'b0;
      case (state_reg)
         FILL: begin
            if (accept) begin
               if (complete && slot_free) begin
                  load           = 1'b1;
                  out_data_next  = fill_merged;
                  out_count_next = cnt_reg + CW'(1);
                  fill_next      = '0;
                  cnt_next       = '0;
               end else if (complete) begin
                  // cnt is kept so the lane count can be restored on transfer
                  fill_next  = fill_merged;
                  state_next = HOLD;
               end else begin
                  fill_next = fill_merged;
                  cnt_next  = cnt_reg + CW'(1);
               end
            end
         end
         HOLD: begin
            if (slot_free) begin
               load           = 1'b1;
               out_data_next  = fill_reg;
               out_count_next = cnt_reg + CW'(1);
               fill_next      = '0;
               cnt_next       = '0;
               state_next     = FILL;
            end
         end
         default: state_next = FILL;
      endcase
      out_valid_next = load ? 1'b1 : (out_ready ? 1'b0 : out_valid_reg);
   end

   always_ff @(posedge clock or posedge clock_sreset) begin
      if (clock_sreset) state_reg <= FILL;
      else              state_reg <= state_next;
   end

   always_ff @(posedge clock or posedge clock_sreset) begin
      if (clock_sreset) begin
         cnt_reg       <= '0;
         fill_reg      <= '0;
         out_data_reg  <= '0;
         out_count_reg <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         cnt_reg       <= cnt_next;
         fill_reg      <= fill_next;
         out_data_reg  <= out_data_next;
         out_count_reg <= out_count_next;
         out_valid_reg <= out_valid_next;
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_count = out_count_reg;

endmodule

// File: tb/tb_fp_vector_packer.sv
// Directed self-checking bench for fp_vector_packer.
module tb_fp_vector_packer;
   localparam int WIDTH = 16;
   localparam int ITEMS = 32;
   localparam int CW    = $clog2(ITEMS + 1);

   logic                        clock = 1'b0;
   logic                        clock_sreset = 1'b0;
   logic                        in_valid = 1'b0;
   logic [WIDTH-1:0]            in_data = '0;
   logic                        in_last = 1'b0;
   logic                        in_ready;
   logic                        out_valid;
   logic                        out_ready = 1'b1;
   logic [ITEMS-1:0][WIDTH-1:0] out_data;
   logic [CW-1:0]               out_count;

   int checks = 0;
   int errors = 0;

   fp_vector_packer #(.WIDTH(WIDTH), .ITEMS(ITEMS), .CW(CW)) dut (
      .clock(clock), .clock_sreset(clock_sreset),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_count(out_count)
   );

   initial forever #5 clock = ~clock;

   task automatic check(input string tag, input logic [ITEMS*WIDTH-1:0] act,
                        input logic [ITEMS*WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, act, exp);
      end else begin
         $display("ok   %s = %0h", tag, act);
      end
   endtask

   // Drive one element, advance one edge, return 1 time unit after it.
   task automatic push(input logic [WIDTH-1:0] d, input logic l);
      in_valid = 1'b1; in_data = d; in_last = l;
      @(posedge clock); #1;
   endtask

   task automatic idle(input logic l);
      in_valid = 1'b0; in_data = '0; in_last = l;
      @(posedge clock); #1;
   endtask

   logic [ITEMS-1:0][WIDTH-1:0] exp_vec;
   logic [ITEMS-1:0][WIDTH-1:0] exp_a;
   int pulses, low_ready, first_k, second_k, dirty;

   initial begin
      // Reset
      clock_sreset = 1'b1;
      @(posedge clock); #1;
      clock_sreset = 1'b0;
      @(posedge clock); #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_count", out_count, 0);
      check("rst_out_data",  out_data, 0);
      check("rst_in_ready",  in_ready, 1);

      // 32 x 1.0 natural fill
      pulses = 0; low_ready = 0;
      for (int i = 0; i < ITEMS; i++) begin
         if (!in_ready) low_ready++;
         push(16'h3f80, 1'b0);
         if (out_valid) pulses++;
      end
      for (int i = 0; i < ITEMS; i++) exp_vec[i] = 16'h3f80;
      check("fill_out_valid", out_valid, 1);
      check("fill_out_count", out_count, 32);
      check("fill_out_data",  out_data, exp_vec);
      idle(1'b0);
      check("fill_valid_drop", out_valid, 0);
      check("fill_pulses", pulses, 1);
      check("fill_ready_lows", low_ready, 0);

      // Early flush of 2 elements
      push(16'h400e, 1'b0);
      push(16'h3f8e, 1'b1);
      exp_vec = '0; exp_vec[0] = 16'h400e; exp_vec[1] = 16'h3f8e;
      check("short_out_valid", out_valid, 1);
      check("short_out_count", out_count, 2);
      check("short_out_data",  out_data, exp_vec);
      idle(1'b0);

      // Two back-to-back vectors
      first_k = -1; second_k = -1; low_ready = 0; pulses = 0;
      for (int k = 0; k < 2 * ITEMS; k++) begin
         if (!in_ready) low_ready++;
         push((k < ITEMS) ? WIDTH'(k) : WIDTH'(16'h4000 + k - ITEMS), 1'b0);
         if (out_valid) begin
            pulses++;
            for (int i = 0; i < ITEMS; i++)
               exp_vec[i] = (k < ITEMS) ? WIDTH'(i) : WIDTH'(16'h4000 + i);
            check("b2b_out_data", out_data, exp_vec);
            check("b2b_out_count", out_count, 32);
            if (first_k < 0) first_k = k; else second_k = k;
         end
      end
      idle(1'b0);
      check("b2b_pulses", pulses, 2);
      check("b2b_first_at", first_k, 31);
      check("b2b_spacing", second_k - first_k, 32);
      check("b2b_ready_lows", low_ready, 0);

      // Backpressure: second completion enters HOLD
      out_ready = 1'b0;
      push(16'h0001, 1'b0);
      push(16'h0002, 1'b1);
      exp_a = '0; exp_a[0] = 16'h0001; exp_a[1] = 16'h0002;
      check("bp_a_valid", out_valid, 1);
      check("bp_a_data",  out_data, exp_a);
      push(16'hbf80, 1'b0);
      push(16'h4040, 1'b0);
      push(16'hc0a0, 1'b1);
      check("bp_hold_ready", in_ready, 0);
      check("bp_hold_data",  out_data, exp_a);
      check("bp_hold_count", out_count, 2);
      idle(1'b0);
      idle(1'b0);
      check("bp_hold2_ready", in_ready, 0);
      check("bp_hold2_data",  out_data, exp_a);
      check("bp_hold2_valid", out_valid, 1);
      out_ready = 1'b1;
      @(posedge clock); #1;
      exp_vec = '0; exp_vec[0] = 16'hbf80; exp_vec[1] = 16'h4040; exp_vec[2] = 16'hc0a0;
      check("bp_b_data",  out_data, exp_vec);
      check("bp_b_count", out_count, 3);
      check("bp_b_valid", out_valid, 1);
      check("bp_b_ready", in_ready, 1);
      @(posedge clock); #1;
      check("bp_b_drop", out_valid, 0);

      // Async reset mid-vector with a held output
      out_ready = 1'b0;
      push(16'h1234, 1'b1);
      check("ar_held_valid", out_valid, 1);
      for (int i = 0; i < 10; i++) push(WIDTH'(16'h5500 + i), 1'b0);
      in_valid = 1'b0; in_last = 1'b0;
      #2 clock_sreset = 1'b1;
      #1;
      check("ar_out_valid", out_valid, 0);
      check("ar_out_data",  out_data, 0);
      check("ar_out_count", out_count, 0);
      @(negedge clock);
      clock_sreset = 1'b0;
      out_ready = 1'b1;
      @(posedge clock); #1;
      check("ar_in_ready", in_ready, 1);
      push(16'h3c00, 1'b0);
      push(16'h3d00, 1'b0);
      push(16'h3e00, 1'b1);
      exp_vec = '0; exp_vec[0] = 16'h3c00; exp_vec[1] = 16'h3d00; exp_vec[2] = 16'h3e00;
      check("ar_new_count", out_count, 3);
      check("ar_new_data",  out_data, exp_vec);
      idle(1'b0);

      // in_last without in_valid is ignored
      pulses = 0; dirty = 0;
      for (int i = 0; i < 5; i++) begin
         push(WIDTH'(16'h4100 + i), 1'b0);
         if (out_valid) pulses++;
      end
      idle(1'b1);
      if (out_valid) pulses++;
      for (int i = 5; i < ITEMS; i++) begin
         push(WIDTH'(16'h4100 + i), 1'b0);
         if (out_valid && i != ITEMS - 1) dirty++;
      end
      for (int i = 0; i < ITEMS; i++) exp_vec[i] = WIDTH'(16'h4100 + i);
      check("ign_early_pulses", pulses + dirty, 0);
      check("ign_out_valid", out_valid, 1);
      check("ign_out_count", out_count, 32);
      check("ign_out_data",  out_data, exp_vec);
      idle(1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fp_vector_packer.md
Name: fp_vector_packer

Overview:
- Producer-side front end for fp_add_tree.
- Collects a serial stream of bfloat16 operands (one per cycle) into an ITEMS-wide vector.
- Presents the vector as a single valid beat on a wide bus that connects directly to the adder tree's data_valid/data inputs.
- Supports early flush of a partial vector; unused lanes are padded with +0.0, which is the additive identity.

Parameters:
- WIDTH, 16: element width in bits (bfloat16 = 1/8/7).
- ITEMS, 32: vector length; must match the downstream fp_add_tree ITEMS.
- CW, $clog2(ITEMS+1): width of the element-count fields.

Ports:
- clock  in  1  system clock, rising edge.
- clock_sreset  in  1  reset, asynchronous, active-high.
- in_valid  in  1  in_data is valid this cycle.
- in_data  in  WIDTH  serial operand.
- in_last  in  1  qualifies in_valid: this element closes the current vector.
- in_ready  out  1  packer accepts an element this cycle.
- out_valid  out  1  out_data holds a complete vector.
- out_ready  in  1  downstream consumes out_data; tie to 1 when feeding fp_add_tree.
- out_data  out  [ITEMS][WIDTH]  packed vector; lane 0 = first element received.
- out_count  out  CW  number of real (non-padded) lanes in out_data, 1..ITEMS.

Behaviour:
- Reset (async assert, any state): state=FILL, fill count=0, fill buffer all zeros, out_valid=0, out_data all zeros, out_count=0. in_ready reads 1 after reset releases.
- Reset mid-vector: any partial vector and any held output are discarded; no out_valid is produced for them.
- Storage: one fill buffer ([ITEMS][WIDTH]) plus one output register. No further queuing.
- FSM has two states, FILL and HOLD.
- in_ready = (state==FILL). It is combinational from state only and never depends on in_valid.
- Accept = in_valid & in_ready.
- On accept: fill[cnt] <= in_data, cnt <= cnt+1.
- Vector completes when accept & (in_last | cnt==ITEMS-1).
- slot_free = !out_valid | out_ready.
- Completion with slot_free:
  - out_data <= fill buffer with the current element merged at lane cnt, all lanes above cnt = 16'h0000.
  - out_count <= cnt+1; out_valid <= 1.
  - cnt <= 0; fill buffer cleared to zeros; state stays FILL.
  - Back-to-back vectors are therefore accepted with no bubble.
- Completion without slot_free: the current element is written, state <= HOLD, in_ready drops next cycle.
- HOLD: wait for slot_free. On slot_free, transfer the fill buffer to the output register, set out_count, out_valid <= 1, clear the fill buffer, cnt <= 0, state <= FILL.
- out_valid falls when out_ready=1 and no transfer occurs in the same cycle. A simultaneous consume and new load keeps out_valid=1 with the new data.
- out_data and out_count are stable while out_valid=1 and out_ready=0.
- Latency: the vector's final element is accepted at edge N; out_valid=1 is visible after edge N (one cycle). In HOLD, out_valid is visible one cycle after the edge where slot_free is seen.
- Boundaries:
  - in_last with in_valid=0 is ignored.
  - in_last on the first element gives out_count=1.
  - in_last on element ITEMS-1 is identical to natural fill.
  - cnt never exceeds ITEMS-1 and never wraps.
  - Padding is always +0.0 (sign bit 0). Element bit patterns pass through untouched; no arithmetic is performed.

Test Plan:
- Reset release, then 32 consecutive elements 16'h3f80 with out_ready=1 -> exactly one out_valid pulse the cycle after element 31; all lanes 16'h3f80; out_count=32; in_ready held 1 throughout.
- Elements 16'h400e, 16'h3f8e with in_last on the second -> out_data[0]=16'h400e, out_data[1]=16'h3f8e, lanes 2..31 = 16'h0000, out_count=2.
- Two back-to-back 32-element vectors (values i and 16'h4000+i), out_ready=1 -> two pulses exactly 32 cycles apart; no in_ready deassertion.
- out_ready=0 while two vectors complete -> second completion enters HOLD; in_ready=0; first vector is held stable. Raising out_ready -> next cycle shows second vector; in_ready=1 again.
- Assert clock_sreset asynchronously after 10 of 32 elements -> outputs zero immediately. Next vector of 3 elements with in_last -> out_count=3; lanes 3..31 are zero (no stale data).
- in_last pulsed with in_valid=0 mid-vector -> ignored; vector completes only at element 32.
